// File: rtl/ycbcr_to_rgb.sv
// rtl/ycbcr_to_rgb.sv - four-stage BT.601 full-range YCbCr to RGB converter
// with coordinate pass-through and a global valid/ready stall.
module ycbcr_to_rgb (
  input  logic        CLK,
  input  logic        iRST_N,
  input  logic [7:0]  iY,
  input  logic [7:0]  iCb,
  input  logic [7:0]  iCr,
  input  logic [15:0] iH_CNT,
  input  logic [15:0] iV_CNT,
  input  logic        iVALID,
  output logic        oREADY,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB,
  output logic [15:0] oH_CNT,
  output logic [15:0] oV_CNT,
  output logic        oVALID,
  input  logic        iREADY
);

  logic        stall;

  logic [3:0]  vld_q, vld_d;
  logic [15:0] h_q [4];
  logic [15:0] v_q [4];

  logic [7:0]  y1_q, y1_d;
  logic [8:0]  cb1_q, cb1_d, cr1_q, cr1_d;

  logic [7:0]  y2_q, y2_d;
  logic [17:0] pr2_q, pr2_d, pgb2_q, pgb2_d, pgr2_q, pgr2_d, pb2_q, pb2_d;

  logic [19:0] sr3_q, sr3_d, sg3_q, sg3_d, sb3_q, sb3_d;

  logic [7:0]  r4_q, r4_d, g4_q, g4_d, b4_q, b4_d;

  logic [19:0] y_q8;

  // Floor of s/256 clamped to 0..255: sign bit means negative, bits 18:16 mean > 255.
  function automatic logic [7:0] clamp8(input logic [19:0] s);
    if (s[19])
      clamp8 = 8'd0;
    else if (|s[18:16])
      clamp8 = 8'hFF;
    else
      clamp8 = s[15:8];
  endfunction

  assign stall  = vld_q[3] && !iREADY;
  assign oREADY = !stall;

  always_comb begin
    vld_d  = {vld_q[2:0], iVALID};
    y1_d   = iY;
    cb1_d  = {1'b0, iCb} - 9'd128;
    cr1_d  = {1'b0, iCr} - 9'd128;

    // Low 18 bits of the product are exact for two's-complement operands.
    y2_d   = y1_q;
    pr2_d  = {{9{cr1_q[8]}}, cr1_q} * 18'd359;
    pgb2_d = {{9{cb1_q[8]}}, cb1_q} * 18'd88;
    pgr2_d = {{9{cr1_q[8]}}, cr1_q} * 18'd183;
    pb2_d  = {{9{cb1_q[8]}}, cb1_q} * 18'd454;

    y_q8   = {4'd0, y2_q, 8'd0};
    sr3_d  = y_q8 + {{2{pr2_q[17]}}, pr2_q} + 20'd128;
    sg3_d  = y_q8 - {{2{pgb2_q[17]}}, pgb2_q} - {{2{pgr2_q[17]}}, pgr2_q} + 20'd128;
    sb3_d  = y_q8 + {{2{pb2_q[17]}}, pb2_q} + 20'd128;

    r4_d   = clamp8(sr3_q);
    g4_d   = clamp8(sg3_q);
    b4_d   = clamp8(sb3_q);
  end

  always_ff @(posedge CLK) begin
    if (!iRST_N) begin
      vld_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        h_q[i] <= '0;
        v_q[i] <= '0;
      end
      y1_q   <= '0;
      cb1_q  <= '0;
      cr1_q  <= '0;
      y2_q   <= '0;
      pr2_q  <= '0;
      pgb2_q <= '0;
      pgr2_q <= '0;
      pb2_q  <= '0;
      sr3_q  <= '0;
      sg3_q  <= '0;
      sb3_q  <= '0;
      r4_q   <= '0;
      g4_q   <= '0;
      b4_q   <= '0;
    end else if (!stall) begin
      vld_q  <= vld_d;
      h_q[0] <= iH_CNT;
      v_q[0] <= iV_CNT;
      for (int i = 1; i < 4; i++) begin
        h_q[i] <= h_q[i-1];
        v_q[i] <= v_q[i-1];
      end
      y1_q   <= y1_d;
      cb1_q  <= cb1_d;
      cr1_q  <= cr1_d;
      y2_q   <= y2_d;
      pr2_q  <= pr2_d;
      pgb2_q <= pgb2_d;
      pgr2_q <= pgr2_d;
      pb2_q  <= pb2_d;
      sr3_q  <= sr3_d;
      sg3_q  <= sg3_d;
      sb3_q  <= sb3_d;
      r4_q   <= r4_d;
      g4_q   <= g4_d;
      b4_q   <= b4_d;
    end
  end

  assign oVALID = vld_q[3];
  assign oR     = r4_q;
  assign oG     = g4_q;
  assign oB     = b4_q;
  assign oH_CNT = h_q[3];
  assign oV_CNT = v_q[3];

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// tb/tb_ycbcr_to_rgb.sv - directed self-checking bench for ycbcr_to_rgb.
module tb_ycbcr_to_rgb;

  logic        clk;
  logic        rst_n;
  logic [7:0]  y, cb, cr;
  logic [15:0] h, v;
  logic        ivalid;
  logic        oready;
  logic [7:0]  r, g, b;
  logic [15:0] oh, ov;
  logic        ovalid;
  logic        iready;

  int n_pass;
  int n_total;

  ycbcr_to_rgb dut (
    .CLK    (clk),
    .iRST_N (rst_n),
    .iY     (y),
    .iCb    (cb),
    .iCr    (cr),
    .iH_CNT (h),
    .iV_CNT (v),
    .iVALID (ivalid),
    .oREADY (oready),
    .oR     (r),
    .oG     (g),
    .oB     (b),
    .oH_CNT (oh),
    .oV_CNT (ov),
    .oVALID (ovalid),
    .iREADY (iready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int clampi(input int s);
    int vv;
    vv = s >>> 8;
    if (vv < 0) return 0;
    if (vv > 255) return 255;
    return vv;
  endfunction

  function automatic logic [23:0] model(input int yy, input int cbb, input int crr);
    int cbp, crp, rr, gg, bb;
    cbp = cbb - 128;
    crp = crr - 128;
    rr = clampi(yy * 256 + 359 * crp + 128);
    gg = clampi(yy * 256 - 88 * cbp - 183 * crp + 128);
    bb = clampi(yy * 256 + 454 * cbp + 128);
    return {rr[7:0], gg[7:0], bb[7:0]};
  endfunction

  task automatic drive(input int yy, input int cbb, input int crr, input int hh, input int vv);
    y = yy[7:0];
    cb = cbb[7:0];
    cr = crr[7:0];
    h = hh[15:0];
    v = vv[15:0];
  endtask

  // Single pixel: absent 3 edges after accept, present after the 4th, gone after the 5th.
  task automatic pixel(input string tag, input int yy, input int cbb, input int crr,
                       input int hh, input int vv, input logic [23:0] exp_rgb);
    drive(yy, cbb, crr, hh, vv);
    ivalid = 1'b1;
    step();
    ivalid = 1'b0;
    step();
    step();
    chk({tag, "_early"}, 48'(ovalid), 48'd0);
    step();
    chk({tag, "_valid"}, 48'(ovalid), 48'd1);
    chk({tag, "_rgb"}, 48'({r, g, b}), 48'(exp_rgb));
    chk({tag, "_coord"}, 48'({oh, ov}), 48'({hh[15:0], vv[15:0]}));
    step();
    chk({tag, "_drop"}, 48'(ovalid), 48'd0);
  endtask

  int py [64];
  int pcb[64];
  int pcr[64];
  int in_idx, out_idx;
  logic prev_stall;
  logic [39:0] held;

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    ivalid = 1'b0;
    iready = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_valid", 48'(ovalid), 48'd0);
    chk("rst_rgb", 48'({r, g, b}), 48'd0);
    chk("rst_coord", 48'({oh, ov}), 48'd0);
    chk("rst_ready", 48'(oready), 48'd1);
    rst_n = 1'b1;
    step();

    pixel("grey", 128, 128, 128, 5, 7, {8'd128, 8'd128, 8'd128});
    pixel("colour", 81, 90, 240, 300, 200, {8'd238, 8'd14, 8'd14});
    pixel("clamp_hi", 255, 128, 255, 1, 2, {8'd255, 8'd164, 8'd255});
    pixel("clamp_lo", 0, 0, 128, 639, 479, {8'd0, 8'd44, 8'd0});

    // Back-to-back streaming, one output per cycle in order.
    for (int i = 0; i < 64; i++) begin
      py[i]  = int'($urandom_range(0, 255));
      pcb[i] = int'($urandom_range(0, 255));
      pcr[i] = int'($urandom_range(0, 255));
    end
    for (int i = 0; i < 67; i++) begin
      if (i < 64) begin
        drive(py[i], pcb[i], pcr[i], i, 262);
        ivalid = 1'b1;
      end else begin
        ivalid = 1'b0;
      end
      step();
      if (i >= 3) begin
        chk("stream_valid", 48'(ovalid), 48'd1);
        chk("stream_rgb", 48'({r, g, b}), 48'(model(py[i-3], pcb[i-3], pcr[i-3])));
        chk("stream_coord", 48'({oh, ov}), 48'({16'(i - 3), 16'd262}));
      end
    end
    ivalid = 1'b0;
    step();
    chk("stream_drain", 48'(ovalid), 48'd0);

    // Backpressure: sink stalls for 5 cycles mid-stream.
    for (int i = 0; i < 10; i++) begin
      py[i]  = int'($urandom_range(0, 255));
      pcb[i] = int'($urandom_range(0, 255));
      pcr[i] = int'($urandom_range(0, 255));
    end
    in_idx = 0;
    out_idx = 0;
    prev_stall = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      iready = !(cyc >= 5 && cyc < 10);
      if (in_idx < 10) begin
        drive(py[in_idx], pcb[in_idx], pcr[in_idx], 100 + in_idx, 9);
        ivalid = 1'b1;
      end else begin
        ivalid = 1'b0;
      end
      #1;
      if (prev_stall)
        chk("bp_hold", 48'({r, g, b, oh}), 48'(held));
      if (ovalid && !iready) begin
        chk("bp_ready_low", 48'(oready), 48'd0);
        prev_stall = 1'b1;
        held = {r, g, b, oh};
      end else begin
        prev_stall = 1'b0;
      end
      if (ovalid && iready) begin
        if (out_idx < 10) begin
          chk("bp_rgb", 48'({r, g, b}), 48'(model(py[out_idx], pcb[out_idx], pcr[out_idx])));
          chk("bp_coord", 48'({oh, ov}), 48'({16'(100 + out_idx), 16'd9}));
        end
        out_idx++;
      end
      if (ivalid && oready)
        in_idx++;
      step();
    end
    chk("bp_count", 48'(out_idx), 48'd10);
    iready = 1'b1;
    ivalid = 1'b0;

    // Reset with three pixels in flight; the same-cycle input must be dropped.
    for (int i = 0; i < 3; i++) begin
      drive(200, 50, 60, 40 + i, 1);
      ivalid = 1'b1;
      step();
    end
    drive(10, 20, 30, 77, 77);
    rst_n = 1'b0;
    step();
    chk("mrst_valid", 48'(ovalid), 48'd0);
    chk("mrst_rgb", 48'({r, g, b}), 48'd0);
    chk("mrst_coord", 48'({oh, ov}), 48'd0);
    chk("mrst_ready", 48'(oready), 48'd1);
    rst_n = 1'b1;
    ivalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mrst_no_stale", 48'(ovalid), 48'd0);
    end
    pixel("post_rst", 128, 128, 128, 11, 12, {8'd128, 8'd128, 8'd128});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ycbcr_to_rgb.md
# ycbcr_to_rgb

Pipelined colour-space converter that turns 8-bit full-range YCbCr (BT.601 coefficients) pixels back into 8-bit RGB. It sits between the YCbCr processing path and the VGA pixel output, the return leg of the RGB-to-YCbCr direction. Pixel screen coordinates travel alongside each pixel, so downstream logic (VGA driver, pixel-sampling HEX display) receives RGB aligned with its own coordinates. Valid/ready handshakes on both sides allow the sink to stall the pipeline.

## Interface
Parameters: none; widths and coefficients are fixed.
- CLK  in  1  single clock; all state updates on posedge
- iRST_N  in  1  synchronous, active-low reset, sampled on posedge CLK
- iY, iCb, iCr  in  8 each  unsigned input pixel components
- iH_CNT, iV_CNT  in  16 each  screen coordinates of the input pixel
- iVALID  in  1  input pixel present
- oREADY  out  1  converter can accept a pixel this cycle
- oR, oG, oB  out  8 each  converted, clamped RGB
- oH_CNT, oV_CNT  out  16 each  coordinates aligned with oR/oG/oB
- oVALID  out  1  output pixel present
- iREADY  in  1  sink accepts the output pixel this cycle

## Operation
- Accept: a pixel enters the pipeline when iVALID && oREADY at a posedge.
- Global stall: stall = oVALID && !iREADY; oREADY = !stall (combinational). While stalled, every pipeline register (data, coordinates, valid bits) holds.
- Bubbles are not compressed. A stall freezes empty stages too.
- Stage 1 (S1): register Y, Cb' = Cb − 128, Cr' = Cr − 128 (9-bit signed), coordinates, and the valid bit.
- Stage 2 (S2): compute products, all Q8 signed: pR = 359·Cr'; pGb = 88·Cb'; pGr = 183·Cr'; pB = 454·Cb'.
- Stage 3 (S3): compute 20-bit signed sums:
  - sR = (Y<<8) + pR + 128
  - sG = (Y<<8) − pGb − pGr + 128
  - sB = (Y<<8) + pB + 128
- Stage 4 (S4): compute v = s >>> 8 (arithmetic, floor). Clamp: v < 0 → 0; v > 255 → 255; otherwise v[7:0]. Drive oR/oG/oB/oH_CNT/oV_CNT/oVALID from S4 registers.
- No intermediate overflow: |s| < 2^19 for all inputs.
- Coordinates are passed through unchanged, delayed identically to the pixel data.
- Output handshake: a pixel leaves when oVALID && iREADY. When an output is consumed and no new pixel arrives behind it, oVALID drops the next cycle. Outputs hold stable while oVALID && !iREADY.

## Timing
- Latency: 4 cycles from accept to oVALID, absent stalls. A stall of N cycles adds N.
- Throughput: 1 pixel/clock while iREADY = 1.
- Reset: while iRST_N = 0 at a posedge, all valid bits clear and all data/coordinate registers go to 0. After that edge: oVALID = 0, oR = oG = oB = 0, oH_CNT = oV_CNT = 0, oREADY = 1.
- Reset mid-stream: all in-flight pixels are discarded and none emerge afterward. An input presented in the same cycle as reset is not accepted.
- Simultaneous accept and emit (iVALID, oREADY, iREADY all 1): both occur; the pipeline advances one stage.
- iREADY falling while oVALID = 0: no stall; the pipeline keeps filling until S4 holds a valid pixel.
- oREADY depends on iREADY combinationally. Sources must not make iVALID depend on oREADY combinationally.

## Test plan
- Neutral grey: Y = 128, Cb = 128, Cr = 128, iREADY = 1 → exactly 4 cycles later oVALID = 1, RGB = (128, 128, 128), coordinates echoed.
- Colour point: Y = 81, Cb = 90, Cr = 240 → RGB = (238, 14, 14).
- Clamping: Y = 255, Cb = 128, Cr = 255 → R = 255 (sum 433 clamps). Y = 0, Cb = 0, Cr = 128 → RGB = (0, 44, 0), B negative clamps to 0.
- Streaming: 64 back-to-back random pixels with iREADY = 1 → 64 outputs on consecutive cycles, in order, matching a reference model and carrying coordinates (H = 0..63, V = 262).
- Backpressure: stream 10 pixels and hold iREADY = 0 for 5 cycles mid-stream → output held stable, oREADY = 0 while oVALID; no loss or duplication; order preserved.
- Reset mid-stream: drive iRST_N = 0 for 1 cycle with 3 pixels in flight → oVALID = 0 and outputs 0 after the edge, no stale pixels emerge, and a new pixel accepted afterward appears 4 cycles later.
